// File: rtl/count_load_arbiter.sv
// Round-robin front end sharing one load_and_count_x4 counter between two clients.
// A winner's start/len are latched, the counter is loaded and run len steps, then its output is checked.
module count_load_arbiter #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int STEP  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0,
  input  logic [WIDTH-1:0] i_start0,
  input  logic [LEN_W-1:0] i_len0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_start1,
  input  logic [LEN_W-1:0] i_len1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_result,
  output logic             o_mismatch,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_ctr_load,
  output logic [WIDTH-1:0] o_ctr_d,
  input  logic [WIDTH-1:0] i_ctr_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK} state_t;

  state_t           r_state, w_next;
  logic             r_last;      // last winner, doubles as owner of the running job
  logic [WIDTH-1:0] r_start;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;
  logic             r_gnt0, r_gnt1, r_done0, r_done1, r_mismatch, r_err;
  logic [WIDTH-1:0] r_result;

  logic             w_any;
  logic             w_win1;
  logic [WIDTH-1:0] w_expected;

  assign w_any      = i_req0 | i_req1;
  assign w_win1     = i_req1 & (~i_req0 | ~r_last);
  assign w_expected = r_start + WIDTH'(STEP) * WIDTH'(r_len);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_LOAD;
      S_LOAD:  w_next = (r_len == '0) ? S_CHECK : S_RUN;
      S_RUN:   if (r_rem == LEN_W'(1)) w_next = S_CHECK;
      S_CHECK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Combinational from state so reset kills the load strobe without a clock.
  always_comb begin
    o_ctr_load = (r_state == S_LOAD);
    o_busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last     <= 1'b1;
      r_start    <= '0;
      r_len      <= '0;
      r_rem      <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
    end else begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt0  <= ~w_win1;
          r_gnt1  <= w_win1;
          r_last  <= w_win1;
          r_start <= w_win1 ? i_start1 : i_start0;
          r_len   <= w_win1 ? i_len1 : i_len0;
        end
        S_LOAD:  r_rem <= r_len;
        S_RUN:   r_rem <= r_rem - LEN_W'(1);
        S_CHECK: begin
          r_result <= i_ctr_out;
          r_done0  <= ~r_last;
          r_done1  <= r_last;
          if (i_ctr_out != w_expected) begin
            r_mismatch <= 1'b1;
            r_err      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gnt0     = r_gnt0;
  assign o_gnt1     = r_gnt1;
  assign o_done0    = r_done0;
  assign o_done1    = r_done1;
  assign o_result   = r_result;
  assign o_mismatch = r_mismatch;
  assign o_err      = r_err;
  assign o_ctr_d    = r_start;

endmodule

// File: tb/tb_count_load_arbiter.sv
// Directed bench for count_load_arbiter with a behavioural +4 counter on the ctr ports.
module tb_count_load_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] start0, start1;
  logic [15:0] len0, len1;
  logic        gnt0, gnt1, done0, done1, mismatch, err, busy, ctr_load;
  logic [31:0] result, ctr_d, ctr_out;
  logic [31:0] cnt = 32'd0;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Counter model: load D, otherwise +4 every clock; fault skews the visible output.
  always_ff @(posedge clk) begin
    if (ctr_load) cnt <= ctr_d;
    else          cnt <= cnt + 32'd4;
  end
  assign ctr_out = cnt + {31'd0, fault};

  count_load_arbiter #(.WIDTH(32), .LEN_W(16), .STEP(4)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req0(req0), .i_start0(start0), .i_len0(len0),
    .i_req1(req1), .i_start1(start1), .i_len1(len1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_result(result), .o_mismatch(mismatch), .o_err(err), .o_busy(busy),
    .o_ctr_load(ctr_load), .o_ctr_d(ctr_d), .i_ctr_out(ctr_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from a single client, checked from grant to done.
  task automatic txn(input string tag, input bit rq, input logic [31:0] st,
                     input logic [15:0] ln, input logic [31:0] exp_res, input bit exp_mm);
    int cyc;
    int nbusy;
    if (rq) begin req1 = 1'b1; start1 = st; len1 = ln; end
    else    begin req0 = 1'b1; start0 = st; len0 = ln; end
    tick();
    chk({tag, "_gnt"},   rq ? gnt1 : gnt0, 1);
    chk({tag, "_gnt_o"}, rq ? gnt0 : gnt1, 0);
    chk({tag, "_load"},  ctr_load, 1);
    chk({tag, "_ctrd"},  ctr_d, st);
    req0 = 1'b0; req1 = 1'b0;
    start0 = 32'hDEAD0000; start1 = 32'hBEEF0000; len0 = 16'd9; len1 = 16'd9;
    cyc = 0;
    nbusy = busy ? 1 : 0;
    while (!(done0 | done1) && cyc < 300) begin
      tick();
      cyc++;
      if (busy) nbusy++;
    end
    chk({tag, "_lat"},    cyc, 32'(ln) + 2);
    chk({tag, "_busy"},   nbusy, 32'(ln) + 2);
    chk({tag, "_done"},   rq ? done1 : done0, 1);
    chk({tag, "_done_o"}, rq ? done0 : done1, 0);
    chk({tag, "_res"},    result, exp_res);
    chk({tag, "_mm"},     mismatch, exp_mm);
    tick();
    chk({tag, "_hold"},   result, exp_res);
    chk({tag, "_pulse"},  done0 | done1 | mismatch, 0);
  endtask

  initial begin
    int ng;
    int last_c;
    rst_n = 1'b0; fault = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    start0 = '0; start1 = '0; len0 = '0; len1 = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_load", ctr_load, 0);
    chk("rst_ctrd", ctr_d, 0);
    chk("rst_res",  result, 0);
    chk("rst_out",  {gnt0, gnt1, done0, done1, mismatch, err}, 0);
    rst_n = 1'b1;
    tick();

    txn("single", 1'b0, 32'd100, 16'd3, 32'd112, 1'b0);
    txn("len0",   1'b1, 32'd7,   16'd0, 32'd7,   1'b0);

    // Continuous contention must alternate starting with requester 0.
    req0 = 1'b1; start0 = 32'd10; len0 = 16'd1;
    req1 = 1'b1; start1 = 32'd20; len1 = 16'd1;
    ng = 0; last_c = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      chk("rr_excl", {31'd0, gnt0 & gnt1}, 0);
      if (gnt0 | gnt1) begin
        chk("rr_order", gnt1, ng % 2);
        if (ng > 0) chk("rr_gap", c - last_c, 4);
        last_c = c;
        ng++;
      end
    end
    chk("rr_count", ng, 4);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
    chk("rr_idle", busy, 0);

    txn("wrap", 1'b0, 32'hFFFFFFFC, 16'd2, 32'h4, 1'b0);

    fault = 1'b1;
    txn("fault", 1'b0, 32'd0, 16'd4, 32'd17, 1'b1);
    fault = 1'b0;
    chk("err_set", err, 1);
    txn("clean", 1'b1, 32'd50, 16'd2, 32'd58, 1'b0);
    chk("err_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    chk("err_clr", err, 0);
    chk("res_clr", result, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Abort a long job partway through RUN.
    req0 = 1'b1; start0 = 32'd0; len0 = 16'd100;
    tick();
    chk("abort_gnt", gnt0, 1);
    req0 = 1'b0;
    repeat (19) tick();
    chk("abort_run", {ctr_load, busy}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out",  {ctr_load, gnt0, gnt1, done0, done1}, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("abort_nodone", {busy, done0, done1}, 0);
    end
    txn("after", 1'b1, 32'd5, 16'd1, 32'd9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_load_arbiter.md
Name: count_load_arbiter

Overview:
- Controller and round-robin arbiter that shares one load_and_count_x4 counter between two requesters.
- A granted requester supplies a start value and a step count. The block loads the counter, lets it run for that many +4 steps, then checks the counter output against the expected value.
- It returns the sampled result and a done pulse to the granted requester.
- Sits between client logic and the counter's load/D/out ports. The counter's own reset is not driven by this block.

Parameters:
WIDTH, 32, counter data width (ctr_D, ctr_out, start, result)
LEN_W, 16, width of the step-count inputs
STEP, 4, counter increment per clock; used for the expected value

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 request, level, held until gnt0
start0  input  WIDTH  requester 0 load value, sampled in grant cycle
len0  input  LEN_W  requester 0 step count, sampled in grant cycle
req1  input  1  requester 1 request
start1  input  WIDTH  requester 1 load value
len1  input  LEN_W  requester 1 step count
gnt0  output  1  one-cycle grant pulse to requester 0
gnt1  output  1  one-cycle grant pulse to requester 1
done0  output  1  one-cycle completion pulse to requester 0
done1  output  1  one-cycle completion pulse to requester 1
result  output  WIDTH  ctr_out sampled in CHECK; valid while a done pulse is high and held until the next CHECK
mismatch  output  1  one-cycle pulse with done when result != expected
err  output  1  sticky mismatch flag, cleared only by reset
busy  output  1  high in LOAD, RUN and CHECK
ctr_load  output  1  drives counter load
ctr_D  output  WIDTH  drives counter D
ctr_out  input  WIDTH  counter output

Behaviour:
- Reset (reset=0, async): state=IDLE; last=1, so requester 0 wins first contention. All outputs 0, including result, ctr_D and err. Remaining-step counter and latched start/len are 0. ctr_load drops immediately, without waiting for a clock.
- FSM states: IDLE, LOAD, RUN, CHECK.
- IDLE arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester that is not equal to `last`.
  - In the grant cycle: register gnt pulse, latch start/len of the winner, set last=winner, go to LOAD.
  - No req: stay in IDLE.
- LOAD (1 cycle): ctr_load=1, ctr_D=latched start. Then remaining=len.
  - len==0: next state CHECK.
  - Otherwise: next state RUN.
- RUN: ctr_load=0. remaining decrements each cycle. Leave for CHECK on the cycle where remaining==1, giving exactly len RUN cycles.
- CHECK (1 cycle):
  - Compute expected = start + STEP*len, mod 2^WIDTH. The multiply is a shift for STEP=4 and is computed on WIDTH bits.
  - Register result=ctr_out; pulse done of the owner.
  - Pulse mismatch and set err if ctr_out != expected.
  - Next state IDLE.
- Latency: done is high exactly len+2 cycles after the gnt cycle's clock edge.
  - Example: len=3 gives gnt at edge n, done at edge n+5.
  - One grant per len+3 cycles maximum; IDLE always costs one cycle.
- Wrap-around: start near 2^WIDTH wraps modulo 2^WIDTH, and the expected value wraps identically. No error from wrap alone.
- ctr_D holds the last loaded value outside LOAD. The counter runs freely while the block is idle; this is legal.
- Request rules:
  - req dropped before grant: not granted, no side effect.
  - req held after done: re-arbitrated normally. Round-robin guarantees alternation under continuous contention.
  - Requests during LOAD/RUN/CHECK are ignored until IDLE.
  - start/len changes after the grant cycle have no effect.
- Reset mid-operation: abort; no done is issued; the owner must re-request.
- gnt0/gnt1 and done0/done1 are never high simultaneously.

Test Plan:
- Single request: req0=1, start0=100, len0=3 -> gnt0 one cycle; ctr_load high one cycle with ctr_D=100; done0 5 cycles after gnt0; result=112; mismatch=0.
- len=0: req1=1, start1=7, len1=0 -> done1 2 cycles after gnt1; result=7; busy high 2 cycles.
- Contention: req0=req1=1 held through four rounds with len=1 -> grants alternate 0,1,0,1 starting with 0; gnt0/gnt1 each one cycle; each round len+3=4 cycles.
- Wrap: start0=32'hFFFFFFFC, len0=2 -> result=32'h4, mismatch=0.
- Fault injection: bench forces ctr_out offset by +1 during CHECK (start0=0, len0=4) -> result=17, mismatch pulses, err=1 and stays 1 through the next clean transaction until reset.
- Reset mid-RUN (len0=100, reset low at cycle 20) -> ctr_load/busy/gnt/done immediately 0, no done0; after release, req1 alone is granted first cycle and completes normally.
